osc_spin_readout: RTL
=====================

# osc_spin_readout

Clocked readout stage that sits directly downstream of the oscillator array. It synchronises the free-running `out` signals of N coupled oscillators into the system clock domain. Over a fixed measurement window it counts, per oscillator, the clock cycles in which that oscillator disagrees with reference oscillator 0. It then resolves each oscillator to a binary spin (in-phase = 0, anti-phase = 1) and hands the spin vector to the host with a start/done handshake.

## Interface
Parameters:
- `N`, 3, number of oscillators observed; `osc_in[0]` is the phase reference.
- `WINDOW`, 256, measurement length in clock cycles; must be even and ≥ 2.
- `SETTLE`, 16, cycles discarded after start before measuring (lets the synchroniser and coupling settle); must be ≥ 1.
- `CW`, `$clog2(WINDOW+1)`, per-oscillator counter width (derived localparam, not overridable).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `osc_in`  in  N  raw oscillator outputs, asynchronous to `clk`.
- `busy`  out  1  high in SETTLE, MEASURE and DONE.
- `done`  out  1  single-cycle pulse; `spins` and `counts` valid from this cycle.
- `spins`  out  N  resolved spins; bit 0 always 0.
- `counts`  out  N*CW  mismatch counters, oscillator i at bits [i*CW +: CW]; count 0 always 0.

## Operation
- Synchroniser: each `osc_in` bit passes through two flops; `sync[i]` is `osc_in[i]` delayed 2 edges. All further logic uses `sync` only.
- States are IDLE, SETTLE, MEASURE and DONE.
- IDLE: if `start` is sampled high, go to SETTLE. On that transition, clear all counters and load the phase timer with SETTLE-1.
- SETTLE: decrement the timer each cycle.
  - At timer 0, go to MEASURE and load the timer with WINDOW-1.
  - No counting in SETTLE.
- MEASURE: every cycle, for i in 1..N-1, `count[i] += sync[i] ^ sync[0]`.
  - At timer 0, that final cycle is counted, then go to DONE.
  - Exactly WINDOW samples are counted.
- DONE: lasts one cycle.
  - `done`=1.
  - `spins[i]` is registered as `count[i] > WINDOW/2`, a strict compare; a tie resolves to 0.
  - Next state is IDLE.
- `spins` holds its value until the next DONE. `counts` holds until the next start is accepted, when counters clear.
- `start` while `busy` is ignored, with no queuing. This includes `start` during DONE.
- Counters cannot overflow: the maximum is WINDOW, which fits in CW bits. No saturation logic is needed.

## Timing
- Reset values: `busy`=0, `done`=0, `spins`=0, `counts`=0. State is IDLE, the timer is 0, and the synchroniser flops are 0.
- Reset asserted mid-operation (any state) forces all of the above on the next edge; no `done` is produced for the aborted run. `rst` has priority over `start` in the same cycle.
- Latency: if `start` is sampled at edge k, the sequence is:
  - SETTLE occupies cycles k+1 … k+SETTLE.
  - MEASURE occupies cycles k+SETTLE+1 … k+SETTLE+WINDOW.
  - `done` is high during cycle k+SETTLE+WINDOW+1.
  - The block returns to IDLE at the following edge.
- `busy` rises in the cycle after the accepting edge and falls together with `done`.
- Minimum start-to-start spacing is SETTLE+WINDOW+2 cycles: a new `start` is accepted the first cycle back in IDLE.
- `spins` and `counts` change only on the DONE entry edge (spins) or the start-accept edge (counts clear). They are stable at all other times.

## Test plan
- In-phase: all `osc_in` driven from one 10 ns-period square wave, `start` pulse → after SETTLE+WINDOW+1 cycles `done`=1, `spins`=3'b000, every `counts` field = 0.
- Anti-phase: `osc_in[1]` = ~`osc_in[0]`, `osc_in[2]` = `osc_in[0]` → `counts[1]`=256, `counts[2]`=0, `spins`=3'b010.
- Tie: `osc_in[0]` held at 0, `osc_in[1]` toggled every clock → `counts[1]`=128 exactly, `spins[1]`=0. Repeat with two extra mismatches (130) → `spins[1]`=1.
- Busy guard: `start` re-pulsed in SETTLE, in MEASURE and in the DONE cycle → exactly one `done` pulse. A `start` in the cycle after `done` → second run begins, `counts` cleared.
- Reset mid-run: `rst` raised for 1 cycle halfway through MEASURE → next cycle `busy`=0, `counts`=0, `spins`=0, no `done` for the aborted run. A fresh `start` yields a correct result.
- Parameter sweep: N=5, WINDOW=8, SETTLE=1 with mixed phases → `done` exactly 10 cycles after the accepting edge, counts within 0..8, `spins[0]`=0.

Source files
------------

// File: rtl/osc_spin_readout.sv
// Oscillator spin readout: synchronises N oscillator outputs, counts per-oscillator
// disagreement with oscillator 0 over a fixed window and resolves binary spins.

module osc_spin_lane #(
  parameter int CW     = 9,
  parameter int WINDOW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          last,
  input  logic          mis,
  output logic [CW-1:0] cnt,
  output logic          spin
);
  localparam logic [CW-1:0] HALF = CW'(WINDOW / 2);

  logic [CW-1:0] cnt_nxt;
  assign cnt_nxt = cnt + CW'(mis);

  // The spin decision includes the final window sample, hence cnt_nxt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      spin <= 1'b0;
    end else begin
      if (clr)     cnt <= '0;
      else if (en) cnt <= cnt_nxt;
      if (en && last) spin <= (cnt_nxt > HALF);
    end
  end
endmodule

module osc_spin_readout #(
  parameter  int N      = 3,
  parameter  int WINDOW = 256,
  parameter  int SETTLE = 16,
  localparam int CW     = $clog2(WINDOW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    osc_in,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    spins,
  output logic [N*CW-1:0] counts
);
  localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEAS, ST_DONE} state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [N-1:0]         sync1, sync;
  logic [N-1:0][CW-1:0] cnt;
  logic                 clr, en, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= osc_in;
      sync  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_SETTLE;
            timer <= TW'(SETTLE - 1);
            busy  <= 1'b1;
          end
        ST_SETTLE:
          if (timer == '0) begin
            state <= ST_MEAS;
            timer <= TW'(WINDOW - 1);
          end else begin
            timer <= timer - TW'(1);
          end
        ST_MEAS:
          if (timer == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clr  = (state == ST_IDLE) && start;
  assign en   = (state == ST_MEAS);
  assign last = (timer == '0);

  // Oscillator 0 is the phase reference: never counts, always spin 0.
  assign cnt[0]   = '0;
  assign spins[0] = 1'b0;

  for (genvar i = 1; i < N; i++) begin : g_lane
    osc_spin_lane #(.CW(CW), .WINDOW(WINDOW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .last (last),
      .mis  (sync[i] ^ sync[0]),
      .cnt  (cnt[i]),
      .spin (spins[i])
    );
  end

  assign counts = cnt;
endmodule
